// File: rtl/uart_pkg.sv
// Shared state encodings and default configuration for the 8N1 UART core.
package uart_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BAUD_RATE  = 115200;
   localparam int DEF_CLOCK_FREQ = 50_000_000;
   localparam int DEF_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // A push into a full FIFO is dropped even when a pop happens in the same cycle.
   assign w_push = i_wr_en && !o_full;
   assign w_pop  = i_rd_en && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Head reads as zero while empty so the host never sees stale storage.
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_core.sv
// 8N1 UART with buffered valid/ready host side; TX and RX state machines live here,
// buffering is done by two uart_sync_fifo instances.
module uart_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  uart_rx,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  uart_tx,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] w_txf_rd_data;
   logic                  w_txf_full;
   logic                  w_txf_empty;
   logic                  w_tx_pop;

   logic [DATA_WIDTH-1:0] w_rxf_rd_data;
   logic                  w_rxf_full;
   logic                  w_rxf_empty;
   logic                  w_rx_push;

   tx_state_t             r_tx_state, w_tx_state_n;
   logic [CNT_W-1:0]      r_tx_cnt,   w_tx_cnt_n;
   logic [BIT_W-1:0]      r_tx_idx,   w_tx_idx_n;
   logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_n;
   logic                  r_tx_line,  w_tx_line_n;

   rx_state_t             r_rx_state, w_rx_state_n;
   logic [CNT_W-1:0]      r_rx_cnt,   w_rx_cnt_n;
   logic [BIT_W-1:0]      r_rx_idx,   w_rx_idx_n;
   logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_n;
   logic                  r_rx_s1;
   logic                  r_rx_s2;

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (tx_valid),
      .i_wr_data (tx_data),
      .i_rd_en   (w_tx_pop),
      .o_rd_data (w_txf_rd_data),
      .o_full    (w_txf_full),
      .o_empty   (w_txf_empty)
   );

   uart_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_rx_push && !w_rxf_full),
      .i_wr_data (r_rx_shift),
      .i_rd_en   (rx_ready),
      .o_rd_data (w_rxf_rd_data),
      .o_full    (w_rxf_full),
      .o_empty   (w_rxf_empty)
   );

   assign tx_ready = !w_txf_full;
   assign rx_valid = !w_rxf_empty;
   assign rx_data  = w_rxf_rd_data;
   assign uart_tx  = r_tx_line;

   // Line driver is a flop preset to 1, so reset forces the idle level asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_cnt   <= w_tx_cnt_n;
         r_tx_idx   <= w_tx_idx_n;
         r_tx_shift <= w_tx_shift_n;
         r_tx_line  <= w_tx_line_n;
      end
   end

   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_cnt_n   = r_tx_cnt;
      w_tx_idx_n   = r_tx_idx;
      w_tx_shift_n = r_tx_shift;
      w_tx_line_n  = r_tx_line;
      w_tx_pop     = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_line_n = 1'b1;
            if (!w_txf_empty) begin
               w_tx_pop     = 1'b1;
               w_tx_shift_n = w_txf_rd_data;
               w_tx_line_n  = 1'b0;
               w_tx_cnt_n   = '0;
               w_tx_state_n = TX_START;
            end
         end
         TX_START: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n   = '0;
               w_tx_idx_n   = '0;
               w_tx_line_n  = r_tx_shift[0];
               w_tx_state_n = TX_DATA;
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         TX_DATA: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n = '0;
               if (r_tx_idx == IDX_LAST) begin
                  w_tx_line_n  = 1'b1;
                  w_tx_state_n = TX_STOP;
               end else begin
                  w_tx_idx_n   = r_tx_idx + 1'b1;
                  w_tx_shift_n = r_tx_shift >> 1;
                  w_tx_line_n  = r_tx_shift[1];
               end
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         TX_STOP: begin
            if (r_tx_cnt == BIT_LAST) begin
               w_tx_cnt_n = '0;
               // Chain straight into the next start bit so bursts have no idle gap.
               if (!w_txf_empty) begin
                  w_tx_pop     = 1'b1;
                  w_tx_shift_n = w_txf_rd_data;
                  w_tx_line_n  = 1'b0;
                  w_tx_state_n = TX_START;
               end else begin
                  w_tx_state_n = TX_IDLE;
               end
            end else begin
               w_tx_cnt_n = r_tx_cnt + 1'b1;
            end
         end
         default: w_tx_state_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_s1    <= uart_rx;
         r_rx_s2    <= r_rx_s1;
         r_rx_state <= w_rx_state_n;
         r_rx_cnt   <= w_rx_cnt_n;
         r_rx_idx   <= w_rx_idx_n;
         r_rx_shift <= w_rx_shift_n;
      end
   end

   always_comb begin
      w_rx_state_n = r_rx_state;
      w_rx_cnt_n   = r_rx_cnt;
      w_rx_idx_n   = r_rx_idx;
      w_rx_shift_n = r_rx_shift;
      w_rx_push    = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_n = '0;
            if (!r_rx_s2) w_rx_state_n = RX_START;
         end
         RX_START: begin
            // Half a bit in: still low means a real start bit, otherwise a glitch.
            if (r_rx_cnt == HALF_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_idx_n   = '0;
               w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_WIDTH-1:1]};
               if (r_rx_idx == IDX_LAST) begin
                  w_rx_state_n = RX_STOP;
               end else begin
                  w_rx_idx_n = r_rx_idx + 1'b1;
               end
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
               w_rx_cnt_n   = '0;
               w_rx_push    = r_rx_s2;
               w_rx_state_n = RX_IDLE;
            end else begin
               w_rx_cnt_n = r_rx_cnt + 1'b1;
            end
         end
         default: w_rx_state_n = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback, TX waveform, flow control, RX robustness, reset.
module tb_uart_core;

   // 50 MHz / 480000 baud -> 104 clocks per bit (integer division of 104.17).
   localparam int CPB = 104;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic       uart_tx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       loop_en;
   logic       rx_drv;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];

   assign uart_rx = loop_en ? uart_tx : rx_drv;

   uart_core #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (480_000),
      .CLOCK_FREQ (50_000_000),
      .FIFO_DEPTH (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .uart_tx  (uart_tx),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   always #10 clk = ~clk;

   // Record every byte the host accepts; rx_ready only changes just after a rising edge.
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) rxq.push_back(rx_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input int i);
      if (i < rxq.size()) return {24'h0, rxq[i]};
      return 32'hDEAD_BEEF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_all();
      tick();
      foreach (txq[k]) begin
         int  w;
         bit  rdy;
         tx_data  = txq[k];
         tx_valid = 1'b1;
         w = 0;
         rdy = 1'b0;
         while (!rdy) begin
            @(negedge clk);
            rdy = tx_ready;
            tick();
            w++;
            if (!rdy && w > 5000) begin
               chk("push_timeout", w, 0);
               tx_valid = 1'b0;
               return;
            end
         end
      end
      tx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      tick();
      rx_drv = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (CPB) tick();
      end
      rx_drv = stop_bit;
      repeat (CPB) tick();
      rx_drv = 1'b1;
      repeat (CPB) tick();
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int c = 0;
      while (rxq.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, rxq.size(), n);
   endtask

   task automatic run_len(input logic lvl, output int len);
      len = 0;
      while (uart_tx === lvl && len < 20 * CPB) begin
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] hello [5];
      int         len;
      int         lat;

      hello    = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      loop_en  = 1'b1;
      rx_drv   = 1'b1;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      rst_n    = 1'b0;
      #100;
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      rst_n = 1'b1;
      repeat (5) tick();

      // Single byte loopback
      rx_ready = 1'b1;
      rxq.delete();
      txq = {8'h48};
      push_all();
      wait_rx(1, 3000, "lb1_count");
      repeat (300) @(negedge clk);
      chk("lb1_once", rxq.size(), 1);
      chk("lb1_data", q_at(0), 8'h48);
      chk("lb1_valid_low", rx_valid, 0);

      // HELLO burst with host stalled
      tick();
      rx_ready = 1'b0;
      rxq.delete();
      txq = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      push_all();
      repeat (6000) @(negedge clk);
      chk("hello_valid_stalled", rx_valid, 1);
      chk("hello_head_stable", rx_data, 8'h48);
      tick();
      rx_ready = 1'b1;
      wait_rx(5, 200, "hello_count");
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) chk($sformatf("hello_byte%0d", i), q_at(i), hello[i]);
      chk("hello_drained", rx_valid, 0);

      // TX waveform for 0x55
      rxq.delete();
      txq = {8'h55};
      push_all();
      lat = 0;
      while (uart_tx && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("tx_latency_ok", (lat <= 3), 1);
      run_len(1'b0, len);
      chk("tx_start_len", len, CPB);
      for (int i = 0; i < 8; i++) begin
         logic lvl;
         lvl = (i % 2 == 0);
         run_len(lvl, len);
         chk($sformatf("tx_bit%0d_len", i), len, CPB);
      end
      repeat (CPB / 2) @(negedge clk);
      chk("tx_stop_level", uart_tx, 1);
      wait_rx(1, 500, "tx55_loop_count");
      chk("tx55_loop_data", q_at(0), 8'h55);
      repeat (2 * CPB) tick();

      // Flow control: 17 pushes fill the FIFO behind the first popped byte
      rxq.delete();
      txq.delete();
      for (int i = 0; i < 17; i++) txq.push_back(8'hA0 + 8'(i));
      push_all();
      @(negedge clk);
      chk("flow_tx_ready_full", tx_ready, 0);
      txq = {8'hB1};
      push_all();
      wait_rx(18, 25000, "flow_count");
      repeat (2 * 10 * CPB) @(negedge clk);
      chk("flow_no_dup", rxq.size(), 18);
      for (int i = 0; i < 17; i++) chk($sformatf("flow_byte%0d", i), q_at(i), 8'hA0 + i);
      chk("flow_byte17", q_at(17), 8'hB1);
      chk("flow_tx_ready_idle", tx_ready, 1);

      // RX robustness with the line driven directly
      tick();
      loop_en = 1'b0;
      rxq.delete();
      rx_drv = 1'b0;
      repeat (40) tick();
      rx_drv = 1'b1;
      repeat (400) tick();
      chk("glitch_no_byte", rxq.size(), 0);
      chk("glitch_valid_low", rx_valid, 0);
      send_frame(8'hA5, 1'b0);
      repeat (300) tick();
      chk("framing_err_dropped", rxq.size(), 0);
      send_frame(8'h3C, 1'b1);
      wait_rx(1, 2000, "good_frame_count");
      chk("good_frame_data", q_at(0), 8'h3C);

      // RX overflow: 17 frames into a 16-entry FIFO
      tick();
      rx_ready = 1'b0;
      rxq.delete();
      for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i), 1'b1);
      send_frame(8'hEE, 1'b1);
      repeat (50) tick();
      chk("ovf_valid", rx_valid, 1);
      chk("ovf_head", rx_data, 8'h10);
      rx_ready = 1'b1;
      wait_rx(16, 200, "ovf_count");
      repeat (5) tick();
      chk("ovf_exact16", rxq.size(), 16);
      for (int i = 0; i < 16; i++) chk($sformatf("ovf_byte%0d", i), q_at(i), 8'h10 + i);
      chk("ovf_drained", rx_valid, 0);

      // Reset in the middle of a frame
      loop_en = 1'b1;
      rxq.delete();
      txq = {8'h00, 8'h81};
      push_all();
      repeat (3 * CPB) @(negedge clk);
      chk("mid_frame_tx_low", uart_tx, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_tx_high", uart_tx, 1);
      chk("rst_mid_tx_ready", tx_ready, 1);
      chk("rst_mid_rx_valid", rx_valid, 0);
      #20;
      rst_n = 1'b1;
      repeat (25 * CPB) @(negedge clk);
      chk("rst_frames_lost", rxq.size(), 0);
      chk("rst_tx_idle", uart_tx, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_core.md
# uart_core

8N1 UART with a valid/ready host interface, used as the serial I/O block of the chiplet SoC. A byte written on the TX side is buffered and serialized on `uart_tx`. Frames arriving on `uart_rx` are deserialized and buffered until the host accepts them, so the host may stall RX for several frames without losing data.

## Interface
- `DATA_WIDTH`, 8: bits per frame payload; also the width of `tx_data` and `rx_data`.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `CLOCK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO; must be a power of two and ≥ 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial input, asynchronous to `clk`, idle high.
- `rx_data` out DATA_WIDTH: head of the RX FIFO (show-ahead).
- `rx_valid` out 1: RX FIFO not empty.
- `rx_ready` in 1: host accepts `rx_data`.
- `uart_tx` out 1: serial output, idle high.
- `tx_data` in DATA_WIDTH: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: TX FIFO not full.

## Operation
- `CLKS_PER_BIT` = CLOCK_FREQ / BAUD_RATE, using integer division; this is 434 at the defaults.
- Frame format: 1 start bit (0), then DATA_WIDTH data bits LSB first, then 1 stop bit (1). No parity.
- **TX push:** on the rising edge where `tx_valid && tx_ready`, `tx_data` is written into the TX FIFO.
- **TX FSM:** states `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`.
  - `TX_IDLE`: when the FIFO is not empty, pop one entry into the shift register and go to `TX_START`.
  - Every bit is held for exactly `CLKS_PER_BIT` cycles.
  - After `TX_STOP`, return to `TX_IDLE`, or go straight to `TX_START` if the FIFO is not empty.
- **RX input:** `uart_rx` passes through a 2-flop synchronizer, whose flops reset to 1.
- **RX FSM:** states `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`.
  - A low level in `RX_IDLE` moves the FSM to `RX_START`.
  - `RX_START` re-samples the line at `CLKS_PER_BIT/2`. If the line is high, the event is a glitch and the FSM returns to `RX_IDLE`.
  - Data bits are sampled every `CLKS_PER_BIT` cycles at bit centre.
  - The stop bit is sampled at its centre. If it is 1, the byte is pushed into the RX FIFO. If it is 0 (framing error), the byte is discarded.
  - In both cases the FSM returns to `RX_IDLE` immediately after the stop-bit sample.
- **RX overflow:** a completed byte arriving while the RX FIFO is full is dropped; FIFO contents are unchanged.
- **RX pop:** on the rising edge where `rx_valid && rx_ready`, the head entry is removed.
- **Simultaneous push and pop:**
  - A simultaneous push and pop on the same FIFO is legal; the occupancy is unchanged.
  - A push while the FIFO is full is ignored, even if a pop occurs in the same cycle.

## Timing
- Reset values:
  - `uart_tx`=1, `rx_valid`=0, `rx_data`=0, `tx_ready`=1.
  - Both FSMs are idle, both FIFOs are empty, and all counters are 0.
- Reset asserted mid-frame: `uart_tx` goes high immediately and asynchronously. Any partial frame and all FIFO contents are lost.
- TX latency: the start bit appears on `uart_tx` at most 2 cycles after a push into an empty FIFO with an idle FSM.
- TX throughput: back-to-back frames from a non-empty FIFO have no idle gap beyond the stop bit.
- `tx_ready` falls on the cycle after the push that fills the FIFO.
- `rx_valid` rises on the cycle after the stop-bit centre sample.
- End-to-end loopback latency is about 9.5 bit times plus 3 cycles from the start-bit edge.
- `rx_data` is stable while `rx_valid` is high and no pop occurs.
- The host-side outputs `rx_data`, `rx_valid` and `tx_ready` are registered or FIFO-flag outputs, with no combinational path from input to output.

## Structure
- Package `uart_pkg`: `tx_state_t` and `rx_state_t` enum typedefs, plus the default constants.
- `CLKS_PER_BIT` is a localparam derived in the core.
- Sub-module `uart_sync_fifo` (parameters WIDTH and DEPTH) is instantiated twice, once for TX and once for RX.
  - Full and empty flags use pointers one bit wider than the address, so wrap-around is handled.
- The TX and RX FSMs stay inline in `uart_core`.

## Test plan
- Reset: hold `rst_n` low for 100 ns -> `uart_tx`=1, `tx_ready`=1, `rx_valid`=0.
- Loopback single byte: push 0x48 with `rx_ready`=1 -> `rx_valid` rises once, `rx_data`=0x48, one pop.
- Burst with RX stalled:
  - Push "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) in loopback with `rx_ready`=0.
  - After 2 ms, raise `rx_ready` -> 5 bytes received in order, then `rx_valid`=0.
- TX waveform: push 0x55 -> `uart_tx` low for 434 cycles, then 1,0,1,0,1,0,1,0 and a stop-bit 1, each held 434 cycles.
- Flow control: push 18 bytes back to back -> `tx_ready` low once the FIFO holds 16 entries; no byte is lost or duplicated.
- RX robustness: drive a 100-cycle low pulse on `uart_rx` -> no byte. Drive a frame for 0xA5 with the stop bit at 0 -> no byte. Drive a 17th frame into a full RX FIFO -> the first 16 bytes are intact.
